wr_burst_packer: RTL and testbench

Upstream stage of wr_master, running in the user clock domain. It packs a narrow user write stream (16-bit words) into 128-bit AXI beats and cuts the stream into fixed-size bursts. It then drives wr_master's user port: data beats with last flags, plus one write command (address, length) per burst. Burst addresses advance linearly through a circular write region.

---
 rtl/wr_burst_packer_pkg.sv | 15 +
 rtl/wr_burst_packer_word_packer.sv | 47 ++++
 rtl/wr_burst_packer.sv | 78 +++++++
 tb/tb_wr_burst_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_burst_packer_pkg.sv
// wr_pkg: default beat/burst geometry, counter-width helper and FSM state encoding shared by wr_burst_packer and wr_word_packer
package wr_pkg;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int USER_W = 16;
  localparam int AXI_W = 128;
  localparam int WR_LEN = 4096;
  localparam int W = AXI_W / USER_W;
  localparam int BB = AXI_W / 8;
  localparam int NB = WR_LEN / BB;
  localparam int WORD_CNT_W = cnt_w(W);
  localparam int BEAT_CNT_W = cnt_w(NB);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CMD} state_t;
endpackage

// File: rtl/wr_burst_packer_word_packer.sv
// wr_word_packer: packs user words into one beat (first word low, or high with WR_PACKER_MSB_FIRST_EN), zero-pads frame tails; ports: clk/rst, wr_data+accept+last in, clr, beat_done (comb), beat_data/beat_valid (registered)
module wr_word_packer
  import wr_pkg::*;
#(
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_AXI_DATA_WIDTH = 128
) (
  input  logic                         i_user_clk,
  input  logic                         i_rst,
  input  logic [P_USER_DATA_WIDTH-1:0] wr_data,
  input  logic                         accept,
  input  logic                         last,
  input  logic                         clr,
  output logic                         beat_done,
  output logic [P_AXI_DATA_WIDTH-1:0]  beat_data,
  output logic                         beat_valid
);
  localparam int words_per_beat = P_AXI_DATA_WIDTH / P_USER_DATA_WIDTH;
  localparam int cw = cnt_w(words_per_beat);
  logic [cw-1:0] cnt;
  logic [cw-1:0] slot;
  logic [P_AXI_DATA_WIDTH-1:0] acc;
  logic [P_AXI_DATA_WIDTH-1:0] acc_n;
  assign beat_done = accept && (last || cnt == cw'(words_per_beat - 1));
`ifdef WR_PACKER_MSB_FIRST_EN
  assign slot = cw'(words_per_beat - 1) - cnt;
`else
  assign slot = cnt;
`endif
  always_comb begin
    acc_n = (cnt == '0) ? '0 : acc;
    acc_n[slot*P_USER_DATA_WIDTH +: P_USER_DATA_WIDTH] = wr_data;
  end
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      acc <= '0;
      beat_data <= '0;
      beat_valid <= 1'b0;
    end else begin
      beat_valid <= beat_done;
      if (accept) acc <= acc_n;
      if (beat_done) beat_data <= acc_n;
      cnt <= (clr || beat_done) ? '0 : accept ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/wr_burst_packer.sv
// wr_burst_packer: packs user words into AXI beats, cuts bursts and issues one command per burst over a circular region; ports: i_user_clk/i_rst, user word stream in, beat stream + command out; WR_PACKER_MSB_FIRST_EN selects MSB-first packing
module wr_burst_packer
  import wr_pkg::*;
#(
  parameter int P_WR_LENGTH = 4096,
  parameter int P_USER_DATA_WIDTH = 16,
  parameter int P_AXI_DATA_WIDTH = 128,
  parameter int P_AXI_ADDR_WIDTH = 32,
  parameter logic [P_AXI_ADDR_WIDTH-1:0] P_BASE_ADDR = 32'h0000_0000,
  parameter logic [P_AXI_ADDR_WIDTH-1:0] P_ADDR_RANGE = 32'h0100_0000
) (
  input  logic                         i_user_clk,
  input  logic                         i_rst,
  input  logic [P_USER_DATA_WIDTH-1:0] i_user_wr_data,
  input  logic                         i_user_wr_valid,
  input  logic                         i_user_wr_last,
  output logic                         o_user_wr_ready,
  output logic [P_AXI_DATA_WIDTH-1:0]  o_axi_u2a_data,
  output logic                         o_axi_u2a_last,
  output logic                         o_axi_u2a_valid,
  output logic                         o_axi_wr_en,
  output logic [P_AXI_ADDR_WIDTH-1:0]  o_axi_wr_addr,
  output logic [7:0]                   o_axi_wr_length
);
  localparam int beat_bytes = P_AXI_DATA_WIDTH / 8;
  localparam int beats_per_burst = P_WR_LENGTH / beat_bytes;
  localparam int bw = cnt_w(beats_per_burst);
  localparam int aw = P_AXI_ADDR_WIDTH;
  localparam int aw1 = P_AXI_ADDR_WIDTH + 1;
  localparam logic [aw:0] region_end = {1'b0, P_BASE_ADDR} + {1'b0, P_ADDR_RANGE};
  state_t state;
  logic accept;
  logic beat_done;
  logic burst_end;
  logic [bw-1:0] bidx;
  logic [aw-1:0] addr;
  logic [aw:0] addr_sum;
  assign o_user_wr_ready = ~i_rst & (state != ST_CMD);
  assign accept = i_user_wr_valid & o_user_wr_ready;
  assign burst_end = beat_done & (i_user_wr_last | (bidx == bw'(beats_per_burst - 1)));
  // advance by bytes actually written; a burst straddling the region end stays whole and wraps afterwards
  assign addr_sum = {1'b0, addr} + aw1'((int'(o_axi_wr_length) + 1) * beat_bytes);
  wr_word_packer #(
    .P_USER_DATA_WIDTH(P_USER_DATA_WIDTH),
    .P_AXI_DATA_WIDTH(P_AXI_DATA_WIDTH)
  ) u_packer (
    .i_user_clk(i_user_clk),
    .i_rst(i_rst),
    .wr_data(i_user_wr_data),
    .accept(accept),
    .last(i_user_wr_last),
    .clr(state == ST_CMD),
    .beat_done(beat_done),
    .beat_data(o_axi_u2a_data),
    .beat_valid(o_axi_u2a_valid)
  );
  always_ff @(posedge i_user_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      bidx <= '0;
      addr <= P_BASE_ADDR;
      o_axi_u2a_last <= 1'b0;
      o_axi_wr_en <= 1'b0;
      o_axi_wr_addr <= '0;
      o_axi_wr_length <= '0;
    end else begin
      o_axi_u2a_last <= burst_end;
      o_axi_wr_en <= burst_end;
      if (burst_end) begin
        o_axi_wr_addr <= addr;
        o_axi_wr_length <= 8'(bidx);
      end
      state <= state == ST_CMD ? ST_RUN : burst_end ? ST_CMD : accept ? ST_RUN : state;
      bidx <= state == ST_CMD ? '0 : beat_done ? bidx + 1'b1 : bidx;
      if (state == ST_CMD) addr <= addr_sum >= region_end ? P_BASE_ADDR : addr_sum[aw-1:0];
    end
  end
endmodule

// File: tb/tb_wr_burst_packer.sv
// tb_wr_burst_packer: table-driven and randomized check of wr_burst_packer against a frame-level reference model
module tb_wr_burst_packer;
  localparam logic [31:0] RANGE_D = 32'h0100_0000;
  localparam logic [31:0] RANGE_R = 32'h0000_2000;
`ifdef WR_PACKER_MSB_FIRST_EN
  localparam logic [127:0] BEAT0 = 128'h0000_0001_0002_0003_0004_0005_0006_0007;
  localparam logic [127:0] PAD19 = {16'd16, 16'd17, 16'd18, 80'h0};
`else
  localparam logic [127:0] BEAT0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] PAD19 = {80'h0, 16'd18, 16'd17, 16'd16};
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] wdata = '0;
  logic wvalid = 1'b0;
  logic wlast = 1'b0;
  logic ready, ready_r, blast, blast_r, bvalid, bvalid_r, en, en_r;
  logic [127:0] bdata, bdata_r;
  logic [31:0] waddr, waddr_r;
  logic [7:0] wlen, wlen_r;
  always #5 clk = ~clk;
  wr_burst_packer dut (
    .i_user_clk(clk), .i_rst(rst), .i_user_wr_data(wdata), .i_user_wr_valid(wvalid),
    .i_user_wr_last(wlast), .o_user_wr_ready(ready), .o_axi_u2a_data(bdata),
    .o_axi_u2a_last(blast), .o_axi_u2a_valid(bvalid), .o_axi_wr_en(en),
    .o_axi_wr_addr(waddr), .o_axi_wr_length(wlen)
  );
  wr_burst_packer #(.P_ADDR_RANGE(RANGE_R)) dut_r (
    .i_user_clk(clk), .i_rst(rst), .i_user_wr_data(wdata), .i_user_wr_valid(wvalid),
    .i_user_wr_last(wlast), .o_user_wr_ready(ready_r), .o_axi_u2a_data(bdata_r),
    .o_axi_u2a_last(blast_r), .o_axi_u2a_valid(bvalid_r), .o_axi_wr_en(en_r),
    .o_axi_wr_addr(waddr_r), .o_axi_wr_length(wlen_r)
  );
  typedef struct packed {logic [127:0] data; logic last;} beat_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] len;} cmd_t;
  typedef struct {
    int pre; bit rst_first; int n; bit l; int exp_beats;
    logic [31:0] exp_addr; logic [31:0] exp_addr_r; logic [7:0] exp_len;
  } vec_t;
  beat_t bq[$];
  cmd_t cq[$];
  cmd_t cqr[$];
  logic [15:0] cur[$];
  int nbeats = 0;
  longint m_addr = 0;
  longint m_addr_r = 0;
  int checks = 0;
  int fails = 0;
  int beats_seen = 0;
  int cmds_seen = 0;
  logic [127:0] first_beat = '0;
  logic [127:0] last_beat = '0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_addr_r = '0;
  logic [7:0] last_len = '0;
  logic prev_en = 1'b0;
  beat_t mb;
  cmd_t mc;
  vec_t tbl[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int slot(input int k);
`ifdef WR_PACKER_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  task automatic model_word(input logic [15:0] d, input logic l);
    beat_t b;
    cmd_t c;
    cur.push_back(d);
    if (cur.size() == 8 || l) begin
      b.data = '0;
      for (int k = 0; k < cur.size(); k++) b.data[slot(k)*16 +: 16] = cur[k];
      nbeats++;
      b.last = l || nbeats == 256;
      bq.push_back(b);
      cur.delete();
      if (b.last) begin
        c.len = 8'(nbeats - 1);
        c.addr = 32'(m_addr);
        cq.push_back(c);
        c.addr = 32'(m_addr_r);
        cqr.push_back(c);
        m_addr += nbeats * 16;
        if (m_addr >= longint'(RANGE_D)) m_addr = 0;
        m_addr_r += nbeats * 16;
        if (m_addr_r >= longint'(RANGE_R)) m_addr_r = 0;
        nbeats = 0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l, input int gap);
    int n;
    for (int g = 0; g < gap; g++) idle();
    @(negedge clk);
    wvalid = 1'b1;
    wdata = d;
    wlast = l;
    n = 0;
    while (!ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_wait", ready, 1'b1);
    else begin
      @(posedge clk);
      model_word(d, l);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    wvalid = 1'b0;
    wlast = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_beat", {bvalid, blast, bdata}, '0);
    check("rst_cmd", {en, waddr, wlen}, '0);
    cur.delete();
    nbeats = 0;
    m_addr = 0;
    m_addr_r = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) prev_en = 1'b0;
    else begin
      if (prev_en) check("ready_after_cmd", ready, 1'b1);
      prev_en = en;
      if (bvalid || bvalid_r || bq.size() > 0) begin
        check("beat_valid", {bvalid, bvalid_r}, {2{bq.size() > 0}});
        if (bq.size() > 0) begin
          mb = bq.pop_front();
          if (bvalid) begin
            check("beat_data", bdata, mb.data);
            check("beat_last", blast, mb.last);
            check("beat_r_data", {blast_r, bdata_r}, {mb.last, mb.data});
          end
        end
        if (bvalid) begin
          if (beats_seen == 0) first_beat = bdata;
          last_beat = bdata;
          beats_seen++;
        end
      end
      if (en || cq.size() > 0) begin
        check("wr_en", en, cq.size() > 0);
        if (cq.size() > 0) begin
          mc = cq.pop_front();
          if (en) begin
            check("wr_addr", waddr, mc.addr);
            check("wr_length", wlen, mc.len);
            check("ready_in_cmd", ready, 1'b0);
          end
        end
        if (en) begin
          cmds_seen++;
          last_addr = waddr;
          last_len = wlen;
        end
      end
      if (en_r || cqr.size() > 0) begin
        check("wr_en_r", en_r, cqr.size() > 0);
        if (cqr.size() > 0) begin
          mc = cqr.pop_front();
          if (en_r) check("wr_cmd_r", {waddr_r, wlen_r}, {mc.addr, mc.len});
        end
        if (en_r) last_addr_r = waddr_r;
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{0,   1, 2048, 0, 256, 32'h0,    32'h0,    8'd255};
    tbl[1]  = '{0,   0, 2048, 0, 256, 32'h1000, 32'h1000, 8'd255};
    tbl[2]  = '{0,   0, 2048, 0, 256, 32'h2000, 32'h0,    8'd255};
    tbl[3]  = '{100, 1, 2048, 0, 256, 32'h0,    32'h0,    8'd255};
    tbl[4]  = '{0,   1, 19,   1, 3,   32'h0,    32'h0,    8'd2};
    tbl[5]  = '{0,   0, 16,   1, 2,   32'h30,   32'h30,   8'd1};
    tbl[6]  = '{0,   0, 8,    1, 1,   32'h50,   32'h50,   8'd0};
    tbl[7]  = '{0,   0, 1,    1, 1,   32'h60,   32'h60,   8'd0};
    tbl[8]  = '{0,   0, 2048, 0, 256, 32'h70,   32'h70,   8'd255};
    tbl[9]  = '{0,   0, 2048, 0, 256, 32'h1070, 32'h1070, 8'd255};
    tbl[10] = '{0,   0, 8,    1, 1,   32'h2070, 32'h0,    8'd0};
    tbl[11] = '{0,   0, 2048, 1, 256, 32'h2080, 32'h10,   8'd255};
    foreach (tbl[e]) begin
      for (int i = 0; i < tbl[e].pre; i++) send(16'(i), 1'b0, 0);
      if (tbl[e].rst_first) begin
        repeat (2) idle();
        do_reset();
      end
      beats_seen = 0;
      cmds_seen = 0;
      for (int i = 0; i < tbl[e].n; i++) send(16'(i), tbl[e].l && i == tbl[e].n - 1, 0);
      repeat (3) idle();
      check($sformatf("vec%0d_beats", e), beats_seen, tbl[e].exp_beats);
      check($sformatf("vec%0d_cmds", e), cmds_seen, 1);
      check($sformatf("vec%0d_addr", e), last_addr, tbl[e].exp_addr);
      check($sformatf("vec%0d_addr_r", e), last_addr_r, tbl[e].exp_addr_r);
      check($sformatf("vec%0d_len", e), last_len, tbl[e].exp_len);
      if (e == 0) check("vec0_beat0", first_beat, BEAT0);
      if (e == 4) check("vec4_pad_beat", last_beat, PAD19);
    end
    for (int f = 0; f < 30; f++) begin
      int len;
      bit l;
      len = $urandom_range(1, 300);
      l = $urandom_range(0, 3) != 0;
      for (int i = 0; i < len; i++)
        send(16'($urandom), l && i == len - 1, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    end
    repeat (3) idle();
    check("queues_drained", bq.size() + cq.size() + cqr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
